// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: in-order pipeline writeback vs. queued MDU results with starvation forcing.
// Optional statistics outputs (stat_force, stat_mdu_wait) are enabled by defining WBARB_STATS_EN.
module wb_port_arbiter #(
   parameter int unsigned MDU_Q_DEPTH  = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_valid,
   input  logic        pipe_load,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   output logic        pipe_stall,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_data,
   output logic        mdu_ready,
   output logic        load_regfile,
   output logic [4:0]  dest,
   output logic [31:0] regfile_in,
   output logic        busy
`ifdef WBARB_STATS_EN
   ,
   output logic [31:0] stat_force,
   output logic [31:0] stat_mdu_wait
`endif
);

   localparam int unsigned PW = $clog2(MDU_Q_DEPTH);
   localparam int unsigned CW = $clog2(MDU_Q_DEPTH + 1);
   localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_FORCE} state_t;

   state_t          r_state;
   logic [SW-1:0]   r_starve;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_started;
   logic [4:0]      r_q_rd   [MDU_Q_DEPTH];
   logic [31:0]     r_q_data [MDU_Q_DEPTH];
   logic            r_load;
   logic [4:0]      r_dest;
   logic [31:0]     r_data;

   logic            w_full;
   logic            w_empty;
   logic            w_preq;
   logic            w_force;
   logic            w_grant_q;
   logic            w_grant_p;
   logic            w_push;
   logic            w_pop;
   logic [CW-1:0]   w_count_nxt;
   logic [4:0]      w_head_rd;
   logic [31:0]     w_head_data;

   always_comb begin
      w_full      = (r_count == CW'(MDU_Q_DEPTH));
      w_empty     = (r_count == '0);
      w_preq      = pipe_valid && pipe_load && (pipe_rd != 5'd0);
      w_force     = (r_state == S_FORCE);
      // FORCE overrides the pipe; otherwise the pipe wins and the queue takes idle slots
      w_grant_q   = !w_empty && (w_force || !w_preq);
      w_grant_p   = !w_force && w_preq;
      w_push      = mdu_valid && mdu_ready;
      w_pop       = w_grant_q;
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
      w_head_rd   = r_q_rd[r_rd_ptr];
      w_head_data = r_q_data[r_rd_ptr];
   end

   assign mdu_ready    = r_started && !w_full;
   assign pipe_stall   = w_force;
   assign load_regfile = r_load;
   assign dest         = r_dest;
   assign regfile_in   = r_data;
   assign busy         = !w_empty || r_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_starve <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_push) r_state <= S_PEND;
            end
            S_PEND: begin
               if (w_pop) begin
                  r_starve <= '0;
                  if (w_count_nxt == '0) r_state <= S_IDLE;
               end else if (w_grant_p) begin
                  if (r_starve == SW'(STARVE_LIMIT - 1)) r_state <= S_FORCE;
                  else r_starve <= r_starve + SW'(1);
               end
            end
            S_FORCE: begin
               r_starve <= '0;
               r_state  <= (w_count_nxt == '0) ? S_IDLE : S_PEND;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
         r_count   <= w_count_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_rd[r_wr_ptr]   <= mdu_rd;
         r_q_data[r_wr_ptr] <= mdu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load <= 1'b0;
         r_dest <= '0;
         r_data <= '0;
      end else if (w_grant_q) begin
         r_load <= (w_head_rd != 5'd0);
         r_dest <= w_head_rd;
         r_data <= w_head_data;
      end else if (w_grant_p) begin
         r_load <= 1'b1;
         r_dest <= pipe_rd;
         r_data <= pipe_data;
      end else begin
         r_load <= 1'b0;
      end
   end

`ifdef WBARB_STATS_EN
   logic [31:0] r_stat_force;
   logic [31:0] r_stat_wait;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_force <= '0;
         r_stat_wait  <= '0;
      end else begin
         if (w_force && (r_stat_force != '1)) r_stat_force <= r_stat_force + 32'd1;
         if (!w_empty && !w_grant_q && (r_stat_wait != '1)) r_stat_wait <= r_stat_wait + 32'd1;
      end
   end

   assign stat_force    = r_stat_force;
   assign stat_mdu_wait = r_stat_wait;
`endif

`ifndef SYNTHESIS
   logic w_waw;

   always_comb begin
      w_waw = 1'b0;
      for (int unsigned i = 0; i < MDU_Q_DEPTH; i++) begin
         if ((CW'(i) < r_count) && (r_q_rd[r_rd_ptr + PW'(i)] == pipe_rd)) w_waw = 1'b1;
      end
   end

   a_no_waw: assert property (@(posedge clk) disable iff (!rst_n) w_grant_p |-> !w_waw);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_port_arbiter;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pipe_valid = 1'b0;
   logic        pipe_load = 1'b0;
   logic [4:0]  pipe_rd = '0;
   logic [31:0] pipe_data = '0;
   logic        pipe_stall;
   logic        mdu_valid = 1'b0;
   logic [4:0]  mdu_rd = '0;
   logic [31:0] mdu_data = '0;
   logic        mdu_ready;
   logic        load_regfile;
   logic [4:0]  dest;
   logic [31:0] regfile_in;
   logic        busy;
`ifdef WBARB_STATS_EN
   logic [31:0] stat_force;
   logic [31:0] stat_mdu_wait;
`endif

   wb_port_arbiter #(.MDU_Q_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_valid(pipe_valid), .pipe_load(pipe_load), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .pipe_stall(pipe_stall),
      .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .load_regfile(load_regfile), .dest(dest), .regfile_in(regfile_in), .busy(busy)
`ifdef WBARB_STATS_EN
      , .stat_force(stat_force), .stat_mdu_wait(stat_mdu_wait)
`endif
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   // Reference model: pending MDU results, consecutive losses of the current head, pending forced slot
   ent_t        mq[$];
   int          m_losses;
   bit          m_force;
   bit          m_started;
   bit          e_load;
   logic [4:0]  e_dest;
   logic [31:0] e_data;
   int          m_sf;
   int          m_sw;

   int          n_stall;
   int          stall_at;
   int          cyc;
   logic [4:0]  wr_log[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_losses  = 0;
      m_force   = 0;
      m_started = 0;
      e_load    = 0;
      e_dest    = '0;
      e_data    = '0;
      m_sf      = 0;
      m_sw      = 0;
   endtask

   task automatic check_outputs();
      bit exp_ready;
      exp_ready = m_started && (mq.size() < DEPTH);
      check("load_regfile", 32'(load_regfile), 32'(e_load));
      if (e_load) begin
         check("dest", 32'(dest), 32'(e_dest));
         check("regfile_in", regfile_in, e_data);
      end
      check("mdu_ready", 32'(mdu_ready), 32'(exp_ready));
      check("pipe_stall", 32'(pipe_stall), 32'(m_force));
      check("busy", 32'(busy), 32'((mq.size() != 0) || e_load));
`ifdef WBARB_STATS_EN
      check("stat_force", stat_force, 32'(m_sf));
      check("stat_mdu_wait", stat_mdu_wait, 32'(m_sw));
`endif
   endtask

   task automatic model_step(input logic pv, input logic pl, input logic [4:0] prd, input logic [31:0] pd,
                             input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      bit   preq, ready, q_wins, p_wins, had_head, next_force;
      ent_t e;
      preq     = pv && pl && (prd != 5'd0);
      ready    = m_started && (mq.size() < DEPTH);
      had_head = (mq.size() != 0);
      q_wins   = had_head && (m_force || !preq);
      p_wins   = !m_force && preq;
      next_force = 0;
      if (m_force) m_sf++;
      if (had_head && !q_wins) m_sw++;
      if (q_wins || m_force) m_losses = 0;
      else if (p_wins && had_head) begin
         m_losses++;
         if (m_losses == LIMIT) next_force = 1;
      end
      if (q_wins) begin
         e = mq.pop_front();
         e_load = (e.rd != 5'd0);
         e_dest = e.rd;
         e_data = e.data;
      end else if (p_wins) begin
         e_load = 1;
         e_dest = prd;
         e_data = pd;
      end else begin
         e_load = 0;
      end
      if (mv && ready) mq.push_back('{rd: mrd, data: md});
      m_force   = next_force;
      m_started = 1;
   endtask

   task automatic cycle(input logic pv, input logic pl, input logic [4:0] prd, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      pipe_valid = pv; pipe_load = pl; pipe_rd = prd; pipe_data = pd;
      mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
      check_outputs();
      if (pipe_stall) begin
         n_stall++;
         stall_at = cyc;
      end
      model_step(pv, pl, prd, pd, mv, mrd, md);
      @(posedge clk);
      #1;
      if (load_regfile) wr_log.push_back(dest);
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      bit          held;
      logic        rpv, rpl, rmv;
      logic [4:0]  rprd, rmrd;
      logic [31:0] rpd, rmd, pkt;

      model_reset();
      cyc = 0;
      n_stall = 0;
      stall_at = -1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_load", 32'(load_regfile), 32'd0);
      check("rst_dest", 32'(dest), 32'd0);
      check("rst_data", regfile_in, 32'd0);
      check("rst_stall", 32'(pipe_stall), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(mdu_ready), 32'd0);
      rst_n = 1'b1;
      idle(2);
      check("ready_after_edge", 32'(mdu_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);

      // Single pipe write
      cycle(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
      check("pipe_load", 32'(load_regfile), 32'd1);
      check("pipe_dest", 32'(dest), 32'd5);
      check("pipe_data", regfile_in, 32'h1234);
      idle(1);
      check("pipe_done", 32'(load_regfile), 32'd0);

      // MDU result with pipe idle; rd=0 pipe packets never write
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE);
      check("mdu_no_bypass", 32'(load_regfile), 32'd0);
      cycle(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      check("mdu_load", 32'(load_regfile), 32'd1);
      check("mdu_dest", 32'(dest), 32'd7);
      check("mdu_data", regfile_in, 32'hCAFE);
      cycle(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
      check("rd0_no_write", 32'(load_regfile), 32'd0);

      // Queue full under continuous pipe traffic, then forced slot
      n_stall = 0;
      stall_at = -1;
      cyc = 0;
      pkt = 32'h5000;
      for (int i = 0; i < 14; i++) begin
         held = m_force;
         cycle(1'b1, 1'b1, 5'd5, pkt, (i < 2) ? 1'b1 : 1'b0, 5'(9 + i), 32'hA000 + 32'(i));
         if (i == 2) check("full_ready", 32'(mdu_ready), 32'd0);
         if (!held) pkt = pkt + 32'd1;
      end
      check("force_count", 32'(n_stall), 32'd1);
      check("force_cycle", 32'(stall_at), 32'd9);
      idle(4);

      // Push and pop every cycle at count 1; order preserved across pointer wrap
      wr_log.delete();
      for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i));
      idle(3);
      check("order_len", 32'(wr_log.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < wr_log.size()) check("order_rd", 32'(wr_log[i]), 32'(i + 1));
      end

      // Random traffic; pipe uses rd 0..15, MDU uses rd 16..31 to respect the upstream WAW guarantee
      held = 0;
      rpv = 0; rpl = 0; rprd = '0; rpd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!held) begin
            rpv  = ($urandom_range(0, 3) != 0);
            rpl  = ($urandom_range(0, 3) != 0);
            rprd = 5'($urandom_range(0, 15));
            rpd  = $urandom;
         end
         rmv  = ($urandom_range(0, 2) == 0);
         rmrd = 5'($urandom_range(16, 31));
         rmd  = $urandom;
         held = m_force;
         cycle(rpv, rpl, rprd, rpd, rmv, rmrd, rmd);
      end
      idle(6);

      // Asynchronous reset with two queued entries
      cycle(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'h2020);
      cycle(1'b1, 1'b1, 5'd3, 32'h34, 1'b1, 5'd21, 32'h2121);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_load", 32'(load_regfile), 32'd0);
      check("arst_dest", 32'(dest), 32'd0);
      check("arst_data", regfile_in, 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_ready", 32'(mdu_ready), 32'd0);
      check("arst_stall", 32'(pipe_stall), 32'd0);
`ifdef WBARB_STATS_EN
      check("arst_stat_force", stat_force, 32'd0);
      check("arst_stat_wait", stat_mdu_wait, 32'd0);
`endif
      model_reset();
      pipe_valid = 1'b0; pipe_load = 1'b0; mdu_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wr_log.delete();
      idle(5);
      check("no_stale_write", 32'(wr_log.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
